// File: rtl/collide_blue.sv
// Tile-map collision prober for the blue character: one pass per frame tick, serialised ROM reads.
// Optional COLLIDE_CORNER_PROBE_EN: two corner probes per side (8 reads) instead of one centre probe.
module collide_blue #(
    parameter int unsigned SPR_W      = 16,
    parameter int unsigned SPR_H      = 16,
    parameter int unsigned TILE_SHIFT = 4,
    parameter int unsigned MAP_COLS   = 40,
    parameter int unsigned MAP_ROWS   = 30,
    parameter int unsigned ADDR_W     = 11,
    parameter int unsigned TILE_BITS  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [9:0]           current_x,
    input  logic [8:0]           current_y,
    output logic [ADDR_W-1:0]    map_addr,
    input  logic [TILE_BITS-1:0] map_data,
    output logic                 busy,
    output logic                 done,
    output logic [3:0]           collision_state
);

`ifdef COLLIDE_CORNER_PROBE_EN
    localparam int unsigned NSLOT  = 8;
    localparam int unsigned SLOT_W = 3;
`else
    localparam int unsigned NSLOT  = 4;
    localparam int unsigned SLOT_W = 2;
`endif
    localparam int unsigned CNT_W = 4;
    localparam int unsigned PW    = 11;

    typedef enum logic [1:0] {IDLE, PROBE, DRAIN, FINISH} state_t;

    state_t            state;
    logic [9:0]        x_q;
    logic [8:0]        y_q;
    logic [CNT_W-1:0]  cnt;
    logic [3:0]        shadow;
    logic              p1_valid, p1_oob, p2_valid, p2_oob;
    logic [1:0]        p1_bit, p2_bit;

    // Returns {out_of_bounds, rom_address} for one probe slot.
    function automatic logic [ADDR_W:0] probe_f(input logic [9:0] x, input logic [8:0] y,
                                               input logic [SLOT_W-1:0] slot);
        logic [PW-1:0] px, py, xa, ya, col, row;
        logic [1:0]    side;
        logic          oob;
        logic [21:0]   lin;
`ifdef COLLIDE_CORNER_PROBE_EN
        side = slot[2:1];
        xa   = slot[0] ? PW'(x) + PW'(SPR_W - 2) : PW'(x) + PW'(1);
        ya   = slot[0] ? PW'(y) + PW'(SPR_H - 2) : PW'(y) + PW'(1);
`else
        side = slot;
        xa   = PW'(x) + PW'(SPR_W / 2);
        ya   = PW'(y) + PW'(SPR_H / 2);
`endif
        oob = 1'b0;
        case (side)
            2'd0: begin px = xa; py = PW'(y) + PW'(SPR_H); end
            2'd1: begin px = xa; py = PW'(y) - PW'(1); oob = (y == 9'd0); end
            2'd2: begin px = PW'(x) + PW'(SPR_W); py = ya; end
            default: begin px = PW'(x) - PW'(1); py = ya; oob = (x == 10'd0); end
        endcase
        col = px >> TILE_SHIFT;
        row = py >> TILE_SHIFT;
        oob = oob | (col >= PW'(MAP_COLS)) | (row >= PW'(MAP_ROWS));
        lin = 22'(row) * 22'(MAP_COLS) + 22'(col);
        return {oob, lin[ADDR_W-1:0]};
    endfunction

    logic              issue;
    logic [SLOT_W-1:0] slot;
    logic [ADDR_W:0]   probe_res;
    logic [1:0]        issue_bit;
    logic [3:0]        shadow_merged;

    // Slot 0 is addressed from the live inputs on the accepting edge so the read pipeline starts at once.
    always_comb begin
        issue     = 1'b0;
        slot      = '0;
        probe_res = '0;
        issue_bit = 2'd0;
        if (state == IDLE) begin
            issue     = start;
            probe_res = probe_f(current_x, current_y, '0);
        end else begin
            issue     = (state == PROBE) && (cnt < CNT_W'(NSLOT));
            slot      = cnt[SLOT_W-1:0];
            probe_res = probe_f(x_q, y_q, slot);
        end
`ifdef COLLIDE_CORNER_PROBE_EN
        issue_bit = slot[2:1];
`else
        issue_bit = slot;
`endif
    end

    always_comb begin
        shadow_merged = shadow;
        if (p2_valid && (p2_oob || (map_data != '0)))
            shadow_merged[p2_bit] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            x_q             <= '0;
            y_q             <= '0;
            cnt             <= '0;
            shadow          <= '0;
            p1_valid        <= 1'b0;
            p1_oob          <= 1'b0;
            p1_bit          <= '0;
            p2_valid        <= 1'b0;
            p2_oob          <= 1'b0;
            p2_bit          <= '0;
            map_addr        <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            collision_state <= '0;
        end else begin
            p2_valid <= p1_valid;
            p2_oob   <= p1_oob;
            p2_bit   <= p1_bit;
            p1_valid <= issue;
            p1_oob   <= probe_res[ADDR_W];
            p1_bit   <= issue_bit;
            if (issue && !probe_res[ADDR_W])
                map_addr <= probe_res[ADDR_W-1:0];
            shadow <= shadow_merged;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        x_q    <= current_x;
                        y_q    <= current_y;
                        cnt    <= CNT_W'(1);
                        shadow <= '0;
                        busy   <= 1'b1;
                        state  <= PROBE;
                    end
                end
                PROBE: begin
                    if (cnt < CNT_W'(NSLOT)) cnt <= cnt + CNT_W'(1);
                    else                     state <= DRAIN;
                end
                DRAIN: begin
                    collision_state <= shadow_merged;
                    done            <= 1'b1;
                    busy            <= 1'b0;
                    state           <= FINISH;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
